mult_control_param: RTL
=======================

MULT_CONTROL_PARAM -- requirements
Module: mult_control_param

Interface
REQ-001 Parameter A_NIB, default 2, number of 4-bit slices of operand A (legal >=1).
REQ-002 Parameter B_NIB, default 2, number of 4-bit slices of operand B (legal >=1).
REQ-003 Derived widths: AW=max(1,clog2(A_NIB)), BW=max(1,clog2(B_NIB)), SW=max(1,clog2(A_NIB+B_NIB-1)).
REQ-004 Ports:
- clk  in  1  rising-edge clock.
- reset_a  in  1  one clock; reset is synchronous and active-high.
- start  in  1  begin a new multiplication (level-sampled each edge).
- a_sel  out  AW  A slice index driving the operand-A mux.
- b_sel  out  BW  B slice index driving the operand-B mux.
- shift_sel  out  SW  partial-product left shift, in nibbles.
- state_out  out  2  IDLE=00, CALC=01, DONE=10, ERR=11.
- clk_ena  out  1  accumulator load enable.
- sclr_n  out  1  accumulator synchronous clear, active-low.
- done  out  1  result valid, one-cycle pulse.
- busy  out  1  high in CALC.
- err  out  1  high in ERR.

Function
REQ-005 Controller owns internal indices a_idx (AW bits) and b_idx (BW bits); no external counter input.
REQ-006 IDLE: clk_ena=0, done=0; start=0 -> sclr_n=1, stay; start=1 -> sclr_n=0 for that cycle, a_idx=b_idx=0, next CALC.
REQ-007 CALC: clk_ena=1, sclr_n=1, a_sel=a_idx, b_sel=b_idx, shift_sel=a_idx+b_idx (zero-extended to SW).
REQ-008 CALC order: a_idx increments each cycle; on a_idx=A_NIB-1 it wraps to 0 and b_idx increments.
REQ-009 CALC with a_idx=A_NIB-1 and b_idx=B_NIB-1 is the last product; next state DONE.
REQ-010 Latency: start sampled in IDLE at edge k -> CALC cycles k+1..k+A_NIB*B_NIB -> done=1 in the following cycle only.
REQ-011 A_NIB=B_NIB=1: exactly one CALC cycle (indices 0, shift 0), then DONE.
REQ-012 DONE: done=1, clk_ena=0, sclr_n=1; start=0 -> IDLE; start=1 -> sclr_n=0, indices cleared, next CALC (back-to-back restart, done still 1).
REQ-013 ERR: err=1, clk_ena=0, sclr_n=1; start=0 -> stay; start=1 -> sclr_n=0, indices cleared, next CALC.
REQ-014 Outside CALC, a_sel, b_sel and shift_sel SHALL be 0.
REQ-015 Outputs are combinational from state, indices and start; state and indices are the only registers.
REQ-016 Unreachable state encodings SHALL go to IDLE on the next edge.

Reset
REQ-017 reset_a high at an edge -> state IDLE, a_idx=b_idx=0, overriding every other input including start.
REQ-018 While reset_a is high, outputs are forced: clk_ena=0, sclr_n=1, done=0, busy=0, err=0, a_sel=b_sel=shift_sel=0, state_out=00.
REQ-019 Reset mid-CALC aborts the multiplication; no done pulse follows.

Configuration
REQ-020 Macro MULT_CTRL_ERR_EN defined: start=1 in CALC -> clk_ena=0 that cycle, next ERR, indices frozen.
REQ-021 Macro MULT_CTRL_ERR_EN undefined: start in CALC is ignored, sequence completes normally, ERR is unreachable and err is tied 0.

Verification
REQ-022 Default 2x2, start 1 cycle -> 4 CALC cycles (a,b,shift)=(0,0,0),(1,0,1),(0,1,1),(1,1,2), clk_ena=1, then done=1 for 1 cycle, IDLE.
REQ-023 A_NIB=4,B_NIB=2 -> 8 CALC cycles, last (3,1,4), done exactly 9 cycles after start edge.
REQ-024 start held high through DONE -> done=1 and sclr_n=0 same cycle, new CALC begins at (0,0,0) next cycle.
REQ-025 ERR_EN defined, start=1 in 2nd CALC cycle -> ERR next, err=1, clk_ena=0; later start=1 -> sclr_n=0, CALC restarts at (0,0,0); undefined -> same stimulus completes 4 products and done.
REQ-026 reset_a=1 in 3rd CALC cycle -> IDLE next edge, all outputs at reset values, no done pulse.
REQ-027 A_NIB=B_NIB=1 -> one CALC cycle (0,0,0), done next cycle.

Source files
------------

// File: rtl/mult_control_param.sv
// rtl/mult_control_param.sv - nibble-serial multiplier sequencer; define MULT_CTRL_ERR_EN to trap start during CALC
module mult_control_param #(
  parameter  int A_NIB = 2,
  parameter  int B_NIB = 2,
  localparam int AW    = (A_NIB > 1) ? $clog2(A_NIB) : 1,
  localparam int BW    = (B_NIB > 1) ? $clog2(B_NIB) : 1,
  localparam int SW    = ((A_NIB + B_NIB - 1) > 1) ? $clog2(A_NIB + B_NIB - 1) : 1
) (
  input  logic          clk,
  input  logic          reset_a,
  input  logic          start,
  output logic [AW-1:0] a_sel,
  output logic [BW-1:0] b_sel,
  output logic [SW-1:0] shift_sel,
  output logic [1:0]    state_out,
  output logic          clk_ena,
  output logic          sclr_n,
  output logic          done,
  output logic          busy,
  output logic          err
);

`ifdef MULT_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Wide enough to hold a_idx + b_idx without overflow before narrowing to SW
  localparam int SUMW = ((AW > BW) ? AW : BW) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_a_idx;
  logic [BW-1:0] r_b_idx;

  logic            w_a_last;
  logic            w_b_last;
  logic            w_err_trap;
  logic [SUMW-1:0] w_sum;

  assign w_a_last   = (r_a_idx == AW'(A_NIB - 1));
  assign w_b_last   = (r_b_idx == BW'(B_NIB - 1));
  assign w_err_trap = ERR_EN & start;
  assign w_sum      = SUMW'(r_a_idx) + SUMW'(r_b_idx);

  // State and slice indices: A index runs fastest, B advances when A wraps
  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state <= S_IDLE;
      r_a_idx <= '0;
      r_b_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CALC;
            r_a_idx <= '0;
            r_b_idx <= '0;
          end
        end
        S_CALC: begin
          if (w_err_trap) begin
            // Indices stay frozen so the aborted position remains observable
            r_state <= S_ERR;
          end else if (w_a_last) begin
            r_a_idx <= '0;
            if (w_b_last) begin
              r_b_idx <= '0;
              r_state <= S_DONE;
            end else begin
              r_b_idx <= r_b_idx + BW'(1);
            end
          end else begin
            r_a_idx <= r_a_idx + AW'(1);
          end
        end
        S_DONE: begin
          r_a_idx <= '0;
          r_b_idx <= '0;
          r_state <= start ? S_CALC : S_IDLE;
        end
        S_ERR: begin
          if (!ERR_EN) begin
            r_state <= S_IDLE;
          end else if (start) begin
            r_state <= S_CALC;
            r_a_idx <= '0;
            r_b_idx <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_a_idx <= '0;
          r_b_idx <= '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from state, indices and the live start input
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    shift_sel = '0;
    state_out = 2'b00;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    done      = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    if (!reset_a) begin
      state_out = r_state;
      case (r_state)
        S_IDLE: begin
          sclr_n = ~start;
        end
        S_CALC: begin
          busy      = 1'b1;
          clk_ena   = ~w_err_trap;
          a_sel     = r_a_idx;
          b_sel     = r_b_idx;
          shift_sel = SW'(w_sum);
        end
        S_DONE: begin
          done   = 1'b1;
          sclr_n = ~start;
        end
        S_ERR: begin
          err    = ERR_EN;
          sclr_n = ~(ERR_EN & start);
        end
        default: begin
          state_out = 2'b00;
        end
      endcase
    end
  end

endmodule
